// File: rtl/common_pkg.sv
// Types and constants shared by the instruction fetch stage and its consumers.
package common;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
   } if_id_type;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order skid buffer between instruction memory and decode.
module fetch_buffer
   import common::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  if_id_type  data,
   output if_id_type  head,
   output logic [1:0] count
);

   if_id_type  entry_q [2];
   if_id_type  entry_d [2];
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       do_pop;
   logic       do_push;
   logic       push_slot;

   always_comb begin
      do_pop    = pop && (count_q != 2'd0);
      do_push   = push && ((count_q != 2'd2) || do_pop);
      // Entry 0 is always the head; a push lands just behind whatever survives the pop.
      push_slot = (count_q == 2'd2) || ((count_q == 2'd1) && !do_pop);
      entry_d   = entry_q;
      count_d   = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         if (do_pop) begin
            entry_d[0] = entry_q[1];
         end
         if (do_push) begin
            entry_d[push_slot] = data;
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entry_q[0] <= '0;
         entry_q[1] <= '0;
         count_q    <= 2'd0;
      end else begin
         entry_q <= entry_d;
         count_q <= count_d;
      end
   end

   assign head  = entry_q[0];
   assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding memory request, redirect/flush handling,
// and a two-entry buffer feeding the decode stage.
module fetch_stage
   import common::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output if_id_type   if_id,
   output logic        if_id_valid
);

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  pc_q;
   logic [31:0]  pc_d;
   logic [31:0]  req_pc_q;
   logic [31:0]  req_pc_d;
   logic [1:0]   buf_count;
   logic [1:0]   count_after;
   logic         buf_push;
   logic         buf_pop;
   logic         req_raw;
   logic         accept;
   if_id_type    buf_head;
   if_id_type    buf_data;

   always_comb begin
      buf_push    = (state_q == WAIT) && imem_rvalid && !redirect;
      buf_pop     = (buf_count != 2'd0) && !stall && !redirect;
      count_after = buf_count + {1'b0, buf_push} - {1'b0, buf_pop};
      // A new request needs a free slot for its own response to land in.
      req_raw     = !redirect && (count_after <= 2'd1) &&
                    ((state_q == REQ) || ((state_q == WAIT) && imem_rvalid));
      accept      = req_raw && imem_ready;
      buf_data    = '{pc: req_pc_q, instruction: imem_rdata};

      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      state_d  = state_q;
      if (redirect) begin
         pc_d    = redirect_pc & 32'hFFFF_FFFC;
         // A response arriving in the redirect cycle is already gone, so nothing is left to drop.
         state_d = ((state_q != REQ) && !imem_rvalid) ? DROP : REQ;
      end else begin
         if (accept) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
         end
         case (state_q)
            REQ:     if (accept) state_d = WAIT;
            WAIT:    if (imem_rvalid) state_d = accept ? WAIT : REQ;
            DROP:    if (imem_rvalid) state_d = REQ;
            default: state_d = REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
      end
   end

   fetch_buffer u_buf (
      .clk   (clk),
      .reset (reset),
      .push  (buf_push),
      .pop   (buf_pop),
      .flush (redirect),
      .data  (buf_data),
      .head  (buf_head),
      .count (buf_count)
   );

   assign imem_req    = req_raw && !reset;
   assign imem_addr   = pc_q;
   assign if_id_valid = (buf_count != 2'd0);
   assign if_id       = if_id_valid ? buf_head : '{pc: 32'h0, instruction: NOP};

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural memory, a contiguous-PC
// reference model, directed scenarios and a randomized phase.
module tb_fetch_stage;
   import common::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   if_id_type   if_id;
   logic        if_id_valid;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .if_id       (if_id),
      .if_id_valid (if_id_valid)
   );

   int checks = 0;
   int errors = 0;
   int delivered = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_accept(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(imem_req && imem_ready) && n < 40);
      checks++;
      if (!(imem_req && imem_ready)) begin
         errors++;
         $display("FAIL %s: no fetch acceptance within 40 cycles", name);
      end
   endtask

   // Memory: 0 random ready, 1 always ready, 2 never ready; response delay in cycles.
   int          ready_mode = 1;
   int          delay_lo = 0;
   int          delay_hi = 0;
   logic        mem_busy = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_wait = 0;

   initial begin
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         imem_rvalid = mem_busy && (mem_wait == 0);
         if (mem_busy && mem_wait > 0) mem_wait--;
         imem_rdata = imem_rvalid ? mem_word(mem_addr) : $urandom();
         case (ready_mode)
            0:       imem_ready = ($urandom_range(0, 1) == 1);
            1:       imem_ready = 1'b1;
            default: imem_ready = 1'b0;
         endcase
         @(negedge clk);
         if (imem_rvalid) mem_busy = 1'b0;
         if (imem_req && imem_ready) begin
            check("one_outstanding", 64'(mem_busy), 64'(1'b0));
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_wait = $urandom_range(delay_hi, delay_lo);
         end
      end
   end

   // Monitor: accepted-but-undelivered fetches, cleared by redirect or reset.
   if_id_type   exp_q[$];
   if_id_type   exp_e;
   if_id_type   hold_val;
   logic [31:0] exp_fetch_pc;
   logic        hold_pending;
   logic        redir_pending;

   initial begin
      exp_fetch_pc  = RST_PC;
      hold_pending  = 1'b0;
      redir_pending = 1'b0;
      hold_val      = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            check("reset_req", 64'(imem_req), 64'(1'b0));
            check("reset_valid", 64'(if_id_valid), 64'(1'b0));
            check("reset_if_id", 64'(if_id), 64'({32'h0, NOP}));
            exp_q.delete();
            exp_fetch_pc  = RST_PC;
            hold_pending  = 1'b0;
            redir_pending = 1'b0;
         end else begin
            if (redir_pending) check("valid_after_redirect", 64'(if_id_valid), 64'(1'b0));
            if (hold_pending) begin
               check("stall_hold_valid", 64'(if_id_valid), 64'(1'b1));
               check("stall_hold_if_id", 64'(if_id), 64'(hold_val));
            end
            if (!if_id_valid) check("empty_if_id", 64'(if_id), 64'({32'h0, NOP}));
            if (redirect) begin
               check("req_on_redirect", 64'(imem_req), 64'(1'b0));
               exp_q.delete();
               exp_fetch_pc = {redirect_pc[31:2], 2'b00};
            end else if (if_id_valid && !stall) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL spurious_valid: got pc %h, required no valid instruction", if_id.pc);
               end else begin
                  exp_e = exp_q.pop_front();
                  check("if_id", 64'(if_id), 64'(exp_e));
                  delivered++;
               end
            end
            if (imem_req && imem_ready && !redirect) begin
               check("fetch_addr", 64'(imem_addr), 64'(exp_fetch_pc));
               exp_q.push_back('{pc: exp_fetch_pc, instruction: mem_word(exp_fetch_pc)});
               exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            redir_pending = redirect;
            hold_pending  = stall && if_id_valid && !redirect;
            hold_val      = if_id;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      repeat (3) @(posedge clk);

      // Reset release, zero-wait memory: consecutive fetches, two-cycle latency.
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("s1_c0_fetch", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h100}));
      check("s1_c0_valid", 64'(if_id_valid), 64'(1'b0));
      @(negedge clk);
      check("s1_c1_fetch", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h104}));
      check("s1_c1_valid", 64'(if_id_valid), 64'(1'b0));
      @(negedge clk);
      check("s1_c2_fetch", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h108}));
      check("s1_c2_if_id", 64'({if_id_valid, if_id.pc}), 64'({1'b1, 32'h100}));
      @(negedge clk);
      check("s1_c3_if_id", 64'({if_id_valid, if_id.pc}), 64'({1'b1, 32'h104}));
      repeat (3) @(negedge clk);

      // Stall for five cycles on a full stream, then release.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1; stall = 1'b1;
         @(negedge clk);
         check("s2_stall_req", 64'(imem_req), 64'(1'b0));
         check("s2_stall_valid", 64'(if_id_valid), 64'(1'b1));
      end
      check("s2_buffer_full", 64'(dut.buf_count), 64'(2'd2));
      base = delivered;
      @(posedge clk); #1; stall = 1'b0;
      repeat (8) @(negedge clk);
      check("s2_resume_flow", 64'(delivered - base >= 7), 64'(1'b1));

      // Redirect while waiting on a slow response.
      @(posedge clk); #2; delay_lo = 2; delay_hi = 2;
      wait_accept("s3_accept");
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h200;
      @(posedge clk); #1; redirect = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!if_id_valid && n < 30);
      check("s3_first_valid_pc", 64'({if_id_valid, if_id.pc}), 64'({1'b1, 32'h200}));

      // Redirect to an unaligned target in the same cycle the response returns.
      @(posedge clk); #2; delay_lo = 0; delay_hi = 0;
      wait_accept("s4_accept");
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'h303;
      @(negedge clk);
      check("s4_rvalid_with_redirect", 64'(imem_rvalid), 64'(1'b1));
      @(posedge clk); #1; redirect = 1'b0;
      @(negedge clk);
      check("s4_next_fetch", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h300}));

      // PC wrap at the top of the address space.
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(posedge clk); #1; redirect = 1'b0;
      wait_accept("s5_accept_top");
      check("s5_top_addr", 64'(imem_addr), 64'(32'hFFFF_FFFC));
      wait_accept("s5_accept_wrap");
      check("s5_wrap_addr", 64'(imem_addr), 64'(32'h0));

      // Reset during an outstanding request; the stale response must be ignored.
      @(posedge clk); #2; delay_lo = 3; delay_hi = 3;
      wait_accept("s6_accept");
      @(posedge clk); #1; reset = 1'b1; #1; ready_mode = 2;
      @(posedge clk); #1; reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("s6_valid", 64'(if_id_valid), 64'(1'b0));
         check("s6_if_id", 64'(if_id), 64'({32'h0, NOP}));
      end
      check("s6_fetch_pending", 64'({imem_req, imem_addr}), 64'({1'b1, RST_PC}));
      @(posedge clk); #2; ready_mode = 1; delay_lo = 0; delay_hi = 0;
      repeat (4) @(negedge clk);

      // Randomized traffic: ready, latency, stall and redirect all vary.
      @(posedge clk); #2; ready_mode = 0; delay_lo = 0; delay_hi = 3;
      base = delivered;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 24) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
      end
      @(posedge clk); #1; stall = 1'b0; redirect = 1'b0;
      #1; ready_mode = 2;
      repeat (12) @(posedge clk);
      #2;
      check("drain_empty", 64'(exp_q.size()), 64'(0));
      check("random_progress", 64'(delivered - base > 200), 64'(1'b1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_ready  in  1  memory accepts the request this cycle when imem_req && imem_ready.
- imem_rvalid  in  1  instruction word returned this cycle; returns at least one cycle after acceptance.
- imem_rdata  in  32  returned instruction word.
- stall  in  1  decode cannot accept if_id this cycle.
- redirect  in  1  branch or jump taken; flush and refetch.
- redirect_pc  in  32  new fetch address.
- if_id  out  if_id_type  {pc, instruction} presented to decode.
- if_id_valid  out  1  if_id holds a real instruction.

Function
REQ-003 The block SHALL allow at most one outstanding memory request.
REQ-004 FSM states:
- REQ: no request outstanding.
- WAIT: response pending, to be kept.
- DROP: response pending, to be discarded.
REQ-005 Transitions:
- REQ -> WAIT on acceptance.
- WAIT -> REQ on imem_rvalid with no new acceptance.
- WAIT -> WAIT on imem_rvalid together with a new acceptance.
- WAIT or DROP -> DROP on redirect.
- DROP -> REQ on imem_rvalid.
REQ-006 imem_req SHALL be asserted in REQ, or in WAIT in the cycle imem_rvalid is high, only when buffer occupancy after this cycle's push and pop is at most 1.
REQ-007 The PC SHALL advance by 4 on each acceptance, unsigned modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-008 In WAIT, imem_rvalid SHALL push {PC of that request, imem_rdata} into a 2-entry in-order buffer.
REQ-009 In DROP, imem_rvalid SHALL push nothing.
REQ-010 if_id_valid SHALL equal "buffer not empty". if_id SHALL be the buffer head.
REQ-011 When the buffer is empty, if_id SHALL be {pc = 0, instruction = NOP 32'h0000_0013}.
REQ-012 The head SHALL pop when if_id_valid && !stall. Under stall, if_id and if_id_valid SHALL stay constant.
REQ-013 Redirect SHALL take priority over stall, push, and pop:
- the buffer is flushed;
- PC <= {redirect_pc[31:2], 2'b00};
- imem_req is deasserted in that cycle;
- if_id_valid is 0 in the next cycle.
REQ-014 A redirect in the same cycle as imem_rvalid in WAIT SHALL discard that response and enter REQ.
REQ-015 With zero-wait memory (imem_ready = 1, imem_rvalid one cycle after acceptance) and no stall, the block SHALL sustain one instruction per cycle.
REQ-016 In that zero-wait, no-stall case, latency SHALL be:
- acceptance in cycle N;
- if_id_valid in cycle N+2.

Reset
REQ-017 While reset is high, the block SHALL hold:
- PC = RESET_PC, state = REQ, buffer empty;
- imem_req = 0, if_id_valid = 0;
- if_id = {0, NOP}.
REQ-018 Assertion of reset mid-request SHALL abandon the outstanding request.
REQ-019 After reset, imem_rvalid SHALL be ignored until the first new acceptance.
REQ-020 imem_req SHALL first assert in the first cycle after reset deasserts.

Structure
REQ-021 The following SHALL live in package common:
- the fetch FSM state enum (REQ, WAIT, DROP);
- the NOP constant 32'h0000_0013;
- if_id_type, which already exists.
REQ-022 The 2-entry buffer SHALL be a sub-module named fetch_buffer, with ports push, pop, flush, data, head, and count.

Verification
REQ-023 A bench SHALL cover these directed scenarios:
- Reset release with RESET_PC = 32'h100 and zero-wait memory -> imem_addr 100, 104, 108 on consecutive cycles; if_id.pc = 100 valid two cycles after first acceptance.
- stall held 5 cycles with a continuous stream -> buffer fills to 2, imem_req drops, if_id stable; stall release -> in-order delivery, no loss or duplication.
- Redirect to 32'h200 while in WAIT (imem_rvalid two cycles later) -> that response is dropped; the next valid if_id has pc = 200.
- Redirect with redirect_pc = 32'h303 in the same cycle as imem_rvalid -> response dropped; next fetch address is 300.
- PC = 32'hFFFF_FFFC -> next fetch address is 32'h0000_0000.
- Reset asserted in WAIT with imem_rvalid arriving after release and before a new acceptance -> ignored; if_id_valid = 0, if_id = {0, NOP}.
